// File: rtl/stack_drain.sv
// Read-side sequencer for the stack register: pops entries count-1..0 (LIFO) and
// streams each one out over a valid/ready handshake, then holds done.
module stack_drain #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk_i,
  input  logic             reset_button_i,
  input  logic             start_i,
  input  logic [7:0]       count_i,
  output logic [AW-1:0]    stk_addr_o,
  output logic             stk_pop_o,
  input  logic [WIDTH-1:0] stk_data_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StEmit,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             err_q, err_d;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          err_d = 1'b0;
          if (count_i == 8'd0) begin
            state_d = StDone;
          end else if (32'(count_i) > DEPTH) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            ptr_d   = AW'(count_i - 8'd1);
            state_d = StFetch;
          end
        end
      end
      StFetch: state_d = StCapture;
      StCapture: begin
        out_data_d = stk_data_i;
        state_d    = StEmit;
      end
      StEmit: begin
        if (out_ready_i) begin
          // ptr stops at 0 so the address never wraps
          if (ptr_q == '0) begin
            state_d = StDone;
          end else begin
            ptr_d   = ptr_q - AW'(1);
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_button_i) begin
    if (reset_button_i) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

  assign stk_addr_o  = ptr_q;
  assign stk_pop_o   = (state_q == StFetch);
  assign out_data_o  = out_data_q;
  assign out_valid_o = (state_q == StEmit);
  assign busy_o      = (state_q == StFetch) || (state_q == StCapture) || (state_q == StEmit);
  assign done_o      = (state_q == StDone);
  assign err_o       = err_q;

endmodule
